// File: rtl/player_physics_ctrl_if.sv
// Bundle between the game logic (master) and the player state engine (slave):
// per-frame controls and obstacle stream in, renderer/HUD status out.
// NUM_LANES must match the NUM_LANES of the attached player_physics_ctrl.
interface player_physics_ctrl_if #(
   parameter int NUM_LANES = 3
);
   localparam int LANE_W = $clog2(NUM_LANES);

   logic                     new_frame;
   logic [15:0]              obstacle;
   logic                     obstacle_valid;
   logic                     firstrow;
   logic                     duck;
   logic                     jump;
   logic                     left;
   logic                     right;
   logic                     game_over;
   logic [LANE_W-1:0]        player_lane;
   logic signed [15:0]       player_height;
   logic [15:0]              player_score;
   logic                     ducking;
   logic                     airborne;

   modport master (
      output new_frame, obstacle, obstacle_valid, firstrow, duck, jump, left, right,
      input  game_over, player_lane, player_height, player_score, ducking, airborne
   );

   modport slave (
      input  new_frame, obstacle, obstacle_valid, firstrow, duck, jump, left, right,
      output game_over, player_lane, player_height, player_score, ducking, airborne
   );
endinterface

// File: rtl/player_physics_ctrl.sv
// Per-frame player state engine: lane, jump/gravity arc, duck timer, ground
// level (ramp / train roof), collision against the first obstacle row, score.
// Obstacles for the collision row are gathered between frames; each new_frame
// pulse commits one complete update in a single clock edge.
module player_physics_ctrl #(
   parameter int NUM_LANES     = 3,
   parameter int GRAVITY       = 3,
   parameter int VERTICAL_JUMP = 10,
   parameter int DUCK_LIMIT    = 15,
   parameter int LOW_CLEAR     = 8,
   parameter int TRAIN_HEIGHT  = 32,
   parameter int SCORE_STEP    = 4
) (
   input logic                  clk,
   input logic                  rst,
   player_physics_ctrl_if.slave bus
);
   localparam int                 LANE_W    = $clog2(NUM_LANES);
   localparam int                 CNT_W     = $clog2(DUCK_LIMIT + 1);
   localparam logic [LANE_W-1:0]  LANE_MAX  = LANE_W'(NUM_LANES - 1);
   localparam logic [LANE_W-1:0]  LANE_RST  = LANE_W'(NUM_LANES / 2);
   localparam logic [LANE_W:0]    LANE_CNT  = (LANE_W + 1)'(NUM_LANES);
   localparam logic [CNT_W-1:0]   CNT_LIMIT = CNT_W'(DUCK_LIMIT);
   localparam logic signed [15:0] TRAIN_H   = 16'(TRAIN_HEIGHT);
   localparam logic signed [15:0] LOW_H     = 16'(LOW_CLEAR);
   localparam logic signed [7:0]  JUMP_V    = 8'(VERTICAL_JUMP);
   localparam logic signed [9:0]  GRAV_V    = 10'(GRAVITY);

   localparam logic [2:0] T_LOW   = 3'b001;
   localparam logic [2:0] T_HIGH  = 3'b010;
   localparam logic [2:0] T_MID   = 3'b011;
   localparam logic [2:0] T_TRAIN = 3'b100;
   localparam logic [2:0] T_RAMP  = 3'b101;
   localparam logic [2:0] T_CAR   = 3'b110;

   typedef enum logic {ALIVE, DEAD} state_t;

   function automatic logic signed [7:0] sat_vel(input logic signed [9:0] v);
      if (v > 10'sd127)       return 8'sd127;
      else if (v < -10'sd127) return -8'sd127;
      else                    return v[7:0];
   endfunction

   function automatic logic signed [15:0] sat_height(input logic signed [16:0] h);
      if (h > 17'sd32767)       return 16'sh7FFF;
      else if (h < -17'sd32768) return 16'sh8000;
      else                      return h[15:0];
   endfunction

   function automatic logic [15:0] sat_score(input logic [16:0] s);
      return s[16] ? 16'hFFFF : s[15:0];
   endfunction

   // Moving cars block a lane exactly like a train car.
   function automatic logic is_train(input logic [2:0] t);
      return (t == T_TRAIN) || (t == T_CAR);
   endfunction

   state_t             state_q, state_n;
   logic [2:0]         row_q [NUM_LANES];
   logic [LANE_W-1:0]  lane_q, lane_n, tgt;
   logic signed [15:0] height_q, height_n, ground, h_sum;
   logic signed [7:0]  vel_q, vel_n;
   logic [CNT_W-1:0]   cnt_q, cnt_n;
   logic               ducking_q, ducking_n, air_q, air_n, hit;
   logic [15:0]        score_q, score_n;
   logic               game_over, frame_go;

   logic [LANE_W-1:0]  obs_lane;
   logic               obs_in_range, obs_unused;

   assign obs_lane     = bus.obstacle[3 +: LANE_W];
   assign obs_in_range = ({1'b0, obs_lane} < LANE_CNT);
   assign obs_unused   = ^bus.obstacle[15:3+LANE_W];

   // Collision-row table: cleared each frame, a coincident obstacle lands in the fresh table.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < NUM_LANES; i++) row_q[i] <= '0;
      end else begin
         if (bus.new_frame)
            for (int i = 0; i < NUM_LANES; i++) row_q[i] <= '0;
         if (bus.obstacle_valid && bus.firstrow && obs_in_range)
            row_q[obs_lane] <= bus.obstacle[2:0];
      end
   end

   // Frame update: lane, duck, ground, vertical motion, collision, score in that order.
   always_comb begin
      tgt       = lane_q;
      lane_n    = lane_q;
      ducking_n = ducking_q;
      cnt_n     = cnt_q;
      vel_n     = vel_q;
      air_n     = air_q;
      height_n  = height_q;
      ground    = '0;
      h_sum     = '0;
      hit       = 1'b0;

      if (bus.left)       tgt = (lane_q == '0)       ? lane_q : lane_q - 1'b1;
      else if (bus.right) tgt = (lane_q == LANE_MAX) ? lane_q : lane_q + 1'b1;
      if (!(is_train(row_q[tgt]) && height_q < TRAIN_H)) lane_n = tgt;

      if (!ducking_q) begin
         if (bus.duck) begin
            ducking_n = 1'b1;
            cnt_n     = CNT_W'(1);
            if (air_q) vel_n = -JUMP_V;
         end
      end else if (cnt_q < CNT_LIMIT) begin
         cnt_n = cnt_q + 1'b1;
      end else if (bus.duck) begin
         cnt_n = CNT_W'(1);
      end else begin
         ducking_n = 1'b0;
         cnt_n     = '0;
      end

      if (is_train(row_q[lane_n]) || row_q[lane_n] == T_RAMP) ground = TRAIN_H;

      // Walking off a roof starts a free fall that is integrated in the same frame.
      if (bus.jump && !air_q && !ducking_n) begin
         vel_n = JUMP_V;
         air_n = 1'b1;
      end else if (!air_q && ground > height_q) begin
         height_n = ground;
      end else if (!air_q && ground < height_q) begin
         air_n = 1'b1;
         vel_n = '0;
      end

      if (air_n) begin
         h_sum = sat_height($signed({height_q[15], height_q}) + $signed({{9{vel_n[7]}}, vel_n}));
         vel_n = sat_vel($signed({{2{vel_n[7]}}, vel_n}) - GRAV_V);
         if (h_sum <= ground) begin
            height_n = ground;
            vel_n    = '0;
            air_n    = 1'b0;
         end else begin
            height_n = h_sum;
         end
      end

      case (row_q[lane_n])
         T_LOW:         hit = (height_n < LOW_H);
         T_HIGH:        hit = !ducking_n;
         T_MID:         hit = !ducking_n && (height_n < LOW_H);
         T_TRAIN, T_CAR: hit = (height_q < TRAIN_H);
         default:       hit = 1'b0;
      endcase

      score_n = hit ? score_q : sat_score({1'b0, score_q} + 17'(SCORE_STEP));
   end

   // Player state registers, committed only on a live frame.
   always_ff @(posedge clk) begin
      if (rst) begin
         lane_q    <= LANE_RST;
         height_q  <= '0;
         vel_q     <= '0;
         cnt_q     <= '0;
         ducking_q <= 1'b0;
         air_q     <= 1'b0;
         score_q   <= '0;
      end else if (frame_go) begin
         lane_q    <= lane_n;
         height_q  <= height_n;
         vel_q     <= vel_n;
         cnt_q     <= cnt_n;
         ducking_q <= ducking_n;
         air_q     <= air_n;
         score_q   <= score_n;
      end
   end

   // Life FSM state register.
   always_ff @(posedge clk) begin
      if (rst) state_q <= ALIVE;
      else     state_q <= state_n;
   end

   // Life FSM next state: a collision on a live frame is fatal and sticky.
   always_comb begin
      state_n = state_q;
      if (state_q == ALIVE && bus.new_frame && hit) state_n = DEAD;
   end

   // Life FSM outputs: frame commit enable and the death flag.
   always_comb begin
      game_over = (state_q == DEAD);
      frame_go  = bus.new_frame && (state_q == ALIVE);
   end

   assign bus.game_over     = game_over;
   assign bus.player_lane   = lane_q;
   assign bus.player_height = height_q;
   assign bus.player_score  = score_q;
   assign bus.ducking       = ducking_q;
   assign bus.airborne      = air_q;
endmodule

// File: tb/tb_player_physics_ctrl.sv
// Directed bench for player_physics_ctrl: a default 3-lane instance plus a
// 5-lane instance for the lane-count scenario. Expected values are hand-derived.
module tb_player_physics_ctrl;
   logic clk = 1'b0;
   logic rst = 1'b0;
   int   n_cmp  = 0;
   int   n_fail = 0;

   always #5 clk = ~clk;

   player_physics_ctrl_if #(.NUM_LANES(3)) bus ();
   player_physics_ctrl_if #(.NUM_LANES(5)) bus5 ();

   player_physics_ctrl #(.NUM_LANES(3)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   player_physics_ctrl #(.NUM_LANES(5)) dut5 (
      .clk (clk),
      .rst (rst),
      .bus (bus5)
   );

   task automatic idle_inputs();
      bus.new_frame = 0; bus.obstacle = '0; bus.obstacle_valid = 0; bus.firstrow = 0;
      bus.duck = 0; bus.jump = 0; bus.left = 0; bus.right = 0;
      bus5.new_frame = 0; bus5.obstacle = '0; bus5.obstacle_valid = 0; bus5.firstrow = 0;
      bus5.duck = 0; bus5.jump = 0; bus5.left = 0; bus5.right = 0;
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1;
      @(negedge clk);
      rst = 0;
   endtask

   // One frame pulse on both instances; outputs are sampled at the closing negedge.
   task automatic frame(input logic l, input logic r, input logic d, input logic j);
      @(negedge clk);
      bus.left = l;  bus.right = r;  bus.duck = d;  bus.jump = j;  bus.new_frame = 1;
      bus5.left = l; bus5.right = r; bus5.duck = d; bus5.jump = j; bus5.new_frame = 1;
      @(negedge clk);
      idle_inputs();
   endtask

   // Frame pulse with a first-row obstacle presented in the same cycle.
   task automatic frame_obs(input logic [2:0] t, input logic [1:0] ln);
      @(negedge clk);
      bus.obstacle = {11'd0, ln, t}; bus.obstacle_valid = 1; bus.firstrow = 1;
      bus.new_frame = 1; bus5.new_frame = 1;
      @(negedge clk);
      idle_inputs();
   endtask

   task automatic put_obs(input logic [2:0] t, input logic [1:0] ln);
      @(negedge clk);
      bus.obstacle = {11'd0, ln, t}; bus.obstacle_valid = 1; bus.firstrow = 1;
      @(negedge clk);
      idle_inputs();
   endtask

   task automatic test_reset();
      do_reset();
      n_cmp++; if (bus.player_lane !== 2'd1) begin n_fail++; $display("FAIL reset_lane: got %0d want 1", bus.player_lane); end
      n_cmp++; if (bus.player_height !== 16'sd0) begin n_fail++; $display("FAIL reset_height: got %0d want 0", bus.player_height); end
      n_cmp++; if (bus.player_score !== 16'd0) begin n_fail++; $display("FAIL reset_score: got %0d want 0", bus.player_score); end
      n_cmp++; if (bus.game_over !== 1'b0) begin n_fail++; $display("FAIL reset_game_over: got %0b want 0", bus.game_over); end
      n_cmp++; if (bus.ducking !== 1'b0) begin n_fail++; $display("FAIL reset_ducking: got %0b want 0", bus.ducking); end
      n_cmp++; if (bus.airborne !== 1'b0) begin n_fail++; $display("FAIL reset_airborne: got %0b want 0", bus.airborne); end
      n_cmp++; if (bus5.player_lane !== 3'd2) begin n_fail++; $display("FAIL reset_lane5: got %0d want 2", bus5.player_lane); end
   endtask

   task automatic test_jump();
      int jh[8] = '{10, 17, 21, 22, 20, 15, 7, 0};
      do_reset();
      for (int i = 0; i < 8; i++) begin
         frame(0, 0, 0, (i == 0));
         n_cmp++;
         if (bus.player_height !== 16'(jh[i])) begin
            n_fail++; $display("FAIL jump_height[%0d]: got %0d want %0d", i, bus.player_height, jh[i]);
         end
         n_cmp++;
         if (bus.airborne !== (i < 7)) begin
            n_fail++; $display("FAIL jump_airborne[%0d]: got %0b want %0b", i, bus.airborne, (i < 7));
         end
      end
      n_cmp++; if (bus.player_score !== 16'd32) begin n_fail++; $display("FAIL jump_score: got %0d want 32", bus.player_score); end
   endtask

   task automatic test_lane_clamp();
      int l3[3] = '{2, 2, 2};
      int l5[3] = '{3, 4, 4};
      do_reset();
      frame(1, 0, 0, 0);
      n_cmp++; if (bus.player_lane !== 2'd0) begin n_fail++; $display("FAIL lane_left: got %0d want 0", bus.player_lane); end
      frame(1, 0, 0, 0);
      n_cmp++; if (bus.player_lane !== 2'd0) begin n_fail++; $display("FAIL lane_clamp_low: got %0d want 0", bus.player_lane); end
      frame(0, 1, 0, 0);
      frame(1, 1, 0, 0);
      n_cmp++; if (bus.player_lane !== 2'd0) begin n_fail++; $display("FAIL lane_left_prio: got %0d want 0", bus.player_lane); end
      do_reset();
      for (int i = 0; i < 3; i++) begin
         frame(0, 1, 0, 0);
         n_cmp++;
         if (bus.player_lane !== 2'(l3[i])) begin n_fail++; $display("FAIL lane_clamp_high[%0d]: got %0d want %0d", i, bus.player_lane, l3[i]); end
         n_cmp++;
         if (bus5.player_lane !== 3'(l5[i])) begin n_fail++; $display("FAIL lane5_right[%0d]: got %0d want %0d", i, bus5.player_lane, l5[i]); end
      end
   endtask

   task automatic test_duck_timing();
      do_reset();
      for (int k = 1; k <= 16; k++) begin
         frame(0, 0, (k == 1), 0);
         n_cmp++;
         if (bus.ducking !== (k <= 15)) begin n_fail++; $display("FAIL duck_single[%0d]: got %0b want %0b", k, bus.ducking, (k <= 15)); end
      end
      // Held for 20 frames: restart at frame 16, then 10 more frames after release.
      do_reset();
      for (int k = 1; k <= 31; k++) begin
         frame(0, 0, (k <= 20), 0);
         if (k == 16 || k == 20 || k == 30 || k == 31) begin
            n_cmp++;
            if (bus.ducking !== (k <= 30)) begin n_fail++; $display("FAIL duck_hold[%0d]: got %0b want %0b", k, bus.ducking, (k <= 30)); end
         end
      end
   endtask

   task automatic test_duck_airborne();
      do_reset();
      frame(0, 0, 0, 1);
      frame(0, 0, 0, 0);
      frame(0, 0, 0, 0);
      n_cmp++; if (bus.player_height !== 16'sd21) begin n_fail++; $display("FAIL fastdrop_pre: got %0d want 21", bus.player_height); end
      frame(0, 0, 1, 0);
      n_cmp++; if (bus.player_height !== 16'sd11) begin n_fail++; $display("FAIL fastdrop_height: got %0d want 11", bus.player_height); end
      n_cmp++; if (bus.ducking !== 1'b1) begin n_fail++; $display("FAIL fastdrop_ducking: got %0b want 1", bus.ducking); end
      frame(0, 0, 0, 0);
      n_cmp++; if (bus.player_height !== 16'sd0 || bus.airborne !== 1'b0) begin
         n_fail++; $display("FAIL fastdrop_land: got h=%0d air=%0b want h=0 air=0", bus.player_height, bus.airborne);
      end
      frame(0, 0, 0, 1);
      n_cmp++; if (bus.airborne !== 1'b0) begin n_fail++; $display("FAIL jump_while_ducking: got %0b want 0", bus.airborne); end
   endtask

   task automatic test_collisions();
      do_reset();
      put_obs(3'b001, 2'd1);
      frame(0, 0, 0, 1);
      n_cmp++; if (bus.game_over !== 1'b0 || bus.player_height !== 16'sd10) begin
         n_fail++; $display("FAIL low_cleared: got go=%0b h=%0d want go=0 h=10", bus.game_over, bus.player_height);
      end
      do_reset();
      put_obs(3'b011, 2'd1);
      frame(0, 0, 1, 0);
      n_cmp++; if (bus.game_over !== 1'b0) begin n_fail++; $display("FAIL mid_ducked: got %0b want 0", bus.game_over); end
      do_reset();
      put_obs(3'b011, 2'd1);
      frame(0, 0, 0, 0);
      n_cmp++; if (bus.game_over !== 1'b1) begin n_fail++; $display("FAIL mid_hit: got %0b want 1", bus.game_over); end
      do_reset();
      put_obs(3'b100, 2'd1);
      frame(0, 0, 0, 0);
      n_cmp++; if (bus.game_over !== 1'b1) begin n_fail++; $display("FAIL train_hit: got %0b want 1", bus.game_over); end
      do_reset();
      put_obs(3'b110, 2'd0);
      frame(1, 0, 0, 0);
      n_cmp++; if (bus.player_lane !== 2'd1 || bus.game_over !== 1'b0) begin
         n_fail++; $display("FAIL car_move_refused: got lane=%0d go=%0b want lane=1 go=0", bus.player_lane, bus.game_over);
      end
      // Kill by moving into a high barrier: the move commits, the score does not.
      do_reset();
      frame(0, 0, 0, 0);
      put_obs(3'b010, 2'd0);
      frame(1, 0, 0, 0);
      n_cmp++; if (bus.game_over !== 1'b1) begin n_fail++; $display("FAIL high_hit: got %0b want 1", bus.game_over); end
      n_cmp++; if (bus.player_score !== 16'd4) begin n_fail++; $display("FAIL kill_score: got %0d want 4", bus.player_score); end
      n_cmp++; if (bus.player_lane !== 2'd0) begin n_fail++; $display("FAIL kill_lane: got %0d want 0", bus.player_lane); end
      frame(0, 1, 1, 1);
      frame(0, 1, 0, 0);
      n_cmp++; if (bus.player_lane !== 2'd0 || bus.player_height !== 16'sd0 || bus.player_score !== 16'd4
                   || bus.ducking !== 1'b0 || bus.airborne !== 1'b0 || bus.game_over !== 1'b1) begin
         n_fail++; $display("FAIL dead_frozen: got lane=%0d h=%0d s=%0d d=%0b a=%0b go=%0b want 0 0 4 0 0 1",
                            bus.player_lane, bus.player_height, bus.player_score, bus.ducking, bus.airborne, bus.game_over);
      end
   endtask

   task automatic test_ramp_train();
      int fh[5] = '{29, 23, 14, 2, 0};
      do_reset();
      put_obs(3'b101, 2'd1);
      frame(0, 0, 0, 0);
      n_cmp++; if (bus.player_height !== 16'sd32 || bus.game_over !== 1'b0) begin
         n_fail++; $display("FAIL ramp_climb: got h=%0d go=%0b want h=32 go=0", bus.player_height, bus.game_over);
      end
      put_obs(3'b100, 2'd1);
      frame(0, 0, 0, 0);
      n_cmp++; if (bus.player_height !== 16'sd32 || bus.game_over !== 1'b0 || bus.airborne !== 1'b0) begin
         n_fail++; $display("FAIL roof_ride: got h=%0d go=%0b a=%0b want h=32 go=0 a=0", bus.player_height, bus.game_over, bus.airborne);
      end
      frame(0, 0, 0, 0);
      n_cmp++; if (bus.airborne !== 1'b1 || bus.player_height !== 16'sd32) begin
         n_fail++; $display("FAIL roof_walkoff: got a=%0b h=%0d want a=1 h=32", bus.airborne, bus.player_height);
      end
      for (int i = 0; i < 5; i++) begin
         frame(0, 0, 0, 0);
         n_cmp++;
         if (bus.player_height !== 16'(fh[i])) begin n_fail++; $display("FAIL roof_fall[%0d]: got %0d want %0d", i, bus.player_height, fh[i]); end
      end
      n_cmp++; if (bus.airborne !== 1'b0) begin n_fail++; $display("FAIL roof_landed: got %0b want 0", bus.airborne); end
   endtask

   task automatic test_table();
      do_reset();
      put_obs(3'b010, 2'd3);
      frame(0, 0, 0, 0);
      n_cmp++; if (bus.game_over !== 1'b0) begin n_fail++; $display("FAIL table_out_of_range: got %0b want 0", bus.game_over); end
      put_obs(3'b010, 2'd1);
      put_obs(3'b000, 2'd1);
      frame(0, 0, 0, 0);
      n_cmp++; if (bus.game_over !== 1'b0) begin n_fail++; $display("FAIL table_last_write: got %0b want 0", bus.game_over); end
      put_obs(3'b010, 2'd2);
      frame(0, 0, 0, 0);
      frame(0, 1, 0, 0);
      n_cmp++; if (bus.game_over !== 1'b0 || bus.player_lane !== 2'd2) begin
         n_fail++; $display("FAIL table_clear: got go=%0b lane=%0d want go=0 lane=2", bus.game_over, bus.player_lane);
      end
      do_reset();
      frame_obs(3'b010, 2'd1);
      n_cmp++; if (bus.game_over !== 1'b0) begin n_fail++; $display("FAIL table_coincident_now: got %0b want 0", bus.game_over); end
      frame(0, 0, 0, 0);
      n_cmp++; if (bus.game_over !== 1'b1) begin n_fail++; $display("FAIL table_coincident_next: got %0b want 1", bus.game_over); end
      do_reset();
      frame(1, 0, 0, 0);
      put_obs(3'b010, 2'd1);
      do_reset();
      n_cmp++; if (bus.player_lane !== 2'd1 || bus.player_score !== 16'd0) begin
         n_fail++; $display("FAIL midframe_reset_outputs: got lane=%0d s=%0d want lane=1 s=0", bus.player_lane, bus.player_score);
      end
      frame(0, 0, 0, 0);
      n_cmp++; if (bus.game_over !== 1'b0 || bus.player_score !== 16'd4) begin
         n_fail++; $display("FAIL midframe_reset_table: got go=%0b s=%0d want go=0 s=4", bus.game_over, bus.player_score);
      end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail + 1);
      $fatal(1, "watchdog");
   end

   initial begin
      idle_inputs();
      test_reset();
      test_jump();
      test_lane_clamp();
      test_duck_timing();
      test_duck_airborne();
      test_collisions();
      test_ramp_train();
      test_table();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end
endmodule

// File: doc/player_physics_ctrl.md
Name: player_physics_ctrl

Overview:
- Per-frame player state engine for the runner game: lane position, jump/gravity arc, duck timer, ground level, collision and score.
- Generalised successor of the first-generation player logic. Adds a parametrised lane count, a full airborne model with ramp and train-roof ground levels, and fast-drop on duck while airborne.
- Builds a first-row obstacle table from the obstacle stream, then applies one update per `new_frame` pulse.
- Feeds the renderer (lane, height, duck) and the HUD (score, game over).

Parameters:
- NUM_LANES, 3, lane count (≥2); LANE_W = $clog2(NUM_LANES).
- GRAVITY, 3, velocity decrement per frame.
- VERTICAL_JUMP, 10, initial upward velocity; fast-drop velocity is its negation.
- DUCK_LIMIT, 15, frames a duck lasts.
- LOW_CLEAR, 8, minimum height that clears low and middle barriers.
- TRAIN_HEIGHT, 32, roof height of a train car; also the ramp-top ground level.
- SCORE_STEP, 4, score added per live frame.

Ports:
- `clk` in 1: system clock.
- `rst` in 1: synchronous active-high reset. One clock; reset is synchronous and active-high.
- `new_frame` in 1: one-cycle pulse; commits one frame update.
- `obstacle` in 16: [2:0] type, [3+:LANE_W] lane, remaining bits ignored.
- `obstacle_valid` in 1: `obstacle` is valid this cycle.
- `firstrow` in 1: the valid obstacle is in the collision row.
- `duck`, `jump`, `left`, `right` in 1 each: player controls, sampled on `new_frame`.
- `game_over` out 1: sticky death flag.
- `player_lane` out LANE_W: current lane, 0 = leftmost.
- `player_height` out 16 signed: height above track.
- `player_score` out 16: saturating score.
- `ducking` out 1: duck active.
- `airborne` out 1: player is in flight.

Behaviour:
- **Reset values:** lane = NUM_LANES/2, height 0, score 0, game_over 0, ducking 0, airborne 0. Internal velocity 0, duck counter 0, row table all 000. `rst` mid-frame discards the partial table.
- **Obstacle types:**
  - 000 none
  - 001 low barrier
  - 010 high barrier
  - 011 middle barrier
  - 100 train
  - 101 ramp
  - 110 moving car, handled as train
  - 111 none
- **Table capture:** on a cycle with `obstacle_valid && firstrow && !new_frame`, write the type into `row[lane]`; last write wins. Lane fields ≥ NUM_LANES are dropped. A valid obstacle on the same cycle as `new_frame` goes into the cleared table for the next frame. The table clears on every `new_frame`.
- **FSM:** ALIVE → DEAD on a collision at a `new_frame` edge. The killing frame's updates are committed. In DEAD all outputs are frozen until `rst`, and inputs are ignored.
- **Frame update, all steps in one `new_frame` edge**, each step using the results of the previous one:
  1. **Lane:** `left` has priority over `right`. The target is clamped to [0, NUM_LANES-1]. The move is refused (lane unchanged, no death) if the target row is train/car and the current height < TRAIN_HEIGHT.
  2. **Duck:** if not ducking and `duck`, start: counter = 1. If ducking and counter < DUCK_LIMIT, increment. At counter = DUCK_LIMIT: restart at 1 if `duck` is held, else end the duck and clear the counter. Starting a duck while airborne forces velocity to -VERTICAL_JUMP.
  3. **Ground:** TRAIN_HEIGHT if `row[lane]` is train/car/ramp, else 0.
  4. **Vertical motion:**
     - Jump: if `jump`, not airborne, and not ducking after step 2, set velocity = VERTICAL_JUMP and airborne = 1.
     - If airborne: h' = h + v, then v = v - GRAVITY. If h' ≤ ground: height = ground, v = 0, airborne = 0; otherwise height = h'.
     - If not airborne and ground > height: snap height to ground (ramp climb).
     - If not airborne and ground < height: airborne = 1 with v = 0 (walked off a roof).
     - Velocity is 8-bit signed and saturates at ±127.
  5. **Collision**, checked in the lane after step 1 using height and ducking after steps 2–4:
     - 001: collides if height < LOW_CLEAR.
     - 010: collides if not ducking.
     - 011: collides if not ducking and height < LOW_CLEAR.
     - Train/car: collides if the pre-update height < TRAIN_HEIGHT and the ground step did not occur via ramp. For train/car, the ramp exception means collide whenever the pre-update height < TRAIN_HEIGHT.
     - Ramp: never collides.
  6. **Score:** += SCORE_STEP, saturating at 16'hFFFF. Not added on the killing frame.
- Outputs are registered and change only on `new_frame` edges or `rst`. Latency: one cycle from the `new_frame` pulse.

Test Plan:
- Jump on empty track, defaults. Pulse `jump` with one `new_frame` → heights 10, 17, 21, 22, 20, 15, 7, then 0 with airborne = 0 on the 8th frame. Score 32 after 8 frames.
- Lane clamp: from lane 0 assert `left` → stays 0. Assert `left` and `right` together from lane 1 → lane 0. With NUM_LANES = 5, reset lane = 2 and `right` ×3 → lane 4.
- Duck timing: hold `duck` one frame → `ducking` high for 15 frames, low at frame 16. Hold `duck` continuously → the counter restarts at 1 with no gap. Duck at height 21 → velocity -10, next height 11.
- Collisions: type 010 in the player lane while not ducking → game_over = 1 and score is not incremented. Type 001 at height 10 → survive. Type 011 while ducking at height 0 → survive. Further `new_frame` pulses after death → all outputs frozen.
- Ramp then train in lane 1: frame A row = 101 → height 32, no death. Frame B row = 100 → survive on roof. Frame C row = 000 → airborne with heights 29, 23, 14, 2, 0.
- Table timing: obstacle in an out-of-range lane is ignored. Obstacle with `obstacle_valid` coinciding with `new_frame` applies on the next frame only. `rst` asserted between table writes → a clean table and reset outputs.
